// File: rtl/aes_cmon_pkg.sv
// Shared types and helpers for the AES ciphertext consistency monitor.
package aes_cmon_pkg;

    typedef enum logic {
        SLOT_EMPTY,
        SLOT_ARMED
    } slot_state_e;

    typedef enum logic {
        ALERT_IDLE,
        ALERT_ACTIVE
    } alert_state_e;

    // Tag/slot index width; a single-slot monitor still carries a 1-bit tag.
    function automatic int tag_width(input int num_slots);
        return (num_slots <= 2) ? 1 : $clog2(num_slots);
    endfunction

endpackage

// File: rtl/aes_ct_consistency_monitor_if.sv
// Observation tap from the AES core output path into the monitor.
interface aes_ct_consistency_monitor_if #(
    parameter int DataWidth = 128,
    parameter int TagWidth  = 2
);
    logic                 obs_valid_i;
    logic [TagWidth-1:0]  obs_tag_i;
    logic [DataWidth-1:0] obs_data_i;

    modport master (output obs_valid_i, output obs_tag_i, output obs_data_i);
    modport slave  (input  obs_valid_i, input  obs_tag_i, input  obs_data_i);
endinterface

// File: rtl/aes_cmon_slot.sv
// One reference context: reference block, iteration/mismatch counters,
// mismatch-period tracking and the compare against the reference.
module aes_cmon_slot
    import aes_cmon_pkg::*;
#(
    parameter int DataWidth   = 128,
    parameter int CntWidth    = 16,
    parameter int AlertThresh = 1
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 clear_i,
    input  logic                 obs_en_i,
    input  logic [DataWidth-1:0] obs_data_i,
    output logic                 match_o,
    output logic                 mismatch_o,
    output logic                 alert_hit_o,
    output logic                 period_hit_o,
    output logic [CntWidth-1:0]  iter_o,
    output logic [CntWidth-1:0]  period_o,
    output logic [DataWidth-1:0] diff_o
);
    localparam logic [CntWidth-1:0] CntMax = '1;
    localparam logic [CntWidth-1:0] Thresh = CntWidth'(AlertThresh);

    slot_state_e          state_q, state_d;
    logic [DataWidth-1:0] ref_q, ref_d;
    logic [CntWidth-1:0]  iter_q, iter_d;
    logic [CntWidth-1:0]  mm_cnt_q, mm_cnt_d;
    logic [CntWidth-1:0]  last_mm_q, last_mm_d;
    logic [CntWidth-1:0]  prev_int_q, prev_int_d;
    logic                 have_last_q, have_last_d;
    logic                 have_prev_q, have_prev_d;
    logic [CntWidth-1:0]  interval;

    // Next-state for one observation; the reference is written only on arming.
    always_comb begin
        state_d      = state_q;
        ref_d        = ref_q;
        iter_d       = iter_q;
        mm_cnt_d     = mm_cnt_q;
        last_mm_d    = last_mm_q;
        prev_int_d   = prev_int_q;
        have_last_d  = have_last_q;
        have_prev_d  = have_prev_q;
        match_o      = 1'b0;
        mismatch_o   = 1'b0;
        alert_hit_o  = 1'b0;
        period_hit_o = 1'b0;
        diff_o       = obs_data_i ^ ref_q;
        if (clear_i) begin
            state_d     = SLOT_EMPTY;
            iter_d      = '0;
            mm_cnt_d    = '0;
            last_mm_d   = '0;
            prev_int_d  = '0;
            have_last_d = 1'b0;
            have_prev_d = 1'b0;
        end else if (obs_en_i) begin
            if (state_q == SLOT_EMPTY) begin
                state_d = SLOT_ARMED;
                ref_d   = obs_data_i;
                iter_d  = '0;
            end else begin
                iter_d = (iter_q == CntMax) ? iter_q : iter_q + 1'b1;
                if (diff_o == '0) begin
                    match_o = 1'b1;
                end else begin
                    mismatch_o  = 1'b1;
                    mm_cnt_d    = (mm_cnt_q == CntMax) ? mm_cnt_q : mm_cnt_q + 1'b1;
                    alert_hit_o = (mm_cnt_d == Thresh) && (mm_cnt_q != Thresh);
                end
            end
        end
        interval = iter_d - last_mm_q;
        iter_o   = iter_d;
        period_o = interval;
        if (mismatch_o) begin
            period_hit_o = have_prev_q && (interval == prev_int_q) && (interval != '0);
            if (have_last_q) begin
                prev_int_d  = interval;
                have_prev_d = 1'b1;
            end
            last_mm_d   = iter_d;
            have_last_d = 1'b1;
        end
    end

    // Slot state registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= SLOT_EMPTY;
            ref_q       <= '0;
            iter_q      <= '0;
            mm_cnt_q    <= '0;
            last_mm_q   <= '0;
            prev_int_q  <= '0;
            have_last_q <= 1'b0;
            have_prev_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ref_q       <= ref_d;
            iter_q      <= iter_d;
            mm_cnt_q    <= mm_cnt_d;
            last_mm_q   <= last_mm_d;
            prev_int_q  <= prev_int_d;
            have_last_q <= have_last_d;
            have_prev_q <= have_prev_d;
        end
    end
endmodule

// File: rtl/aes_ct_consistency_monitor.sv
// Online ciphertext consistency monitor: tag decode, per-slot compare,
// registered result pulses, sticky alert FSM with first-mismatch capture.
module aes_ct_consistency_monitor
    import aes_cmon_pkg::*;
#(
    parameter  int DataWidth   = 128,
    parameter  int NumSlots    = 4,
    parameter  int CntWidth    = 16,
    parameter  int AlertThresh = 1,
    localparam int TagWidth    = tag_width(NumSlots)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 clear_i,
    input  logic                 alert_clr_i,
    aes_ct_consistency_monitor_if.slave obs,
    output logic                 match_o,
    output logic                 mismatch_o,
    output logic                 tag_err_o,
    output logic                 alert_o,
    output logic                 cap_valid_o,
    output logic [TagWidth-1:0]  cap_slot_o,
    output logic [CntWidth-1:0]  cap_iter_o,
    output logic [DataWidth-1:0] cap_diff_o,
    output logic                 period_valid_o,
    output logic [CntWidth-1:0]  period_o
);
    typedef struct packed {
        logic [TagWidth-1:0]  slot;
        logic [CntWidth-1:0]  iter;
        logic [DataWidth-1:0] diff;
    } capture_t;

    logic                 accept, tag_ok;
    logic [NumSlots-1:0]  slot_en, s_match, s_mismatch, s_alert_hit, s_period_hit;
    logic [CntWidth-1:0]  s_iter [NumSlots];
    logic [CntWidth-1:0]  s_period [NumSlots];
    logic [DataWidth-1:0] s_diff [NumSlots];

    logic                 sel_match, sel_mismatch, sel_alert_hit, sel_period_hit;
    logic [CntWidth-1:0]  sel_period;
    capture_t             sel_cap;

    logic                 match_q, match_d, mismatch_q, mismatch_d;
    logic                 tag_err_q, tag_err_d, period_valid_q, period_valid_d;
    logic [CntWidth-1:0]  period_q, period_d;

    alert_state_e         alert_state_q;
    logic                 cap_valid_q;
    capture_t             cap_q;

    // clear_i drops any same-cycle observation, including bad tags.
    assign accept = obs.obs_valid_i && !clear_i;
    assign tag_ok = int'(obs.obs_tag_i) < NumSlots;

    for (genvar g = 0; g < NumSlots; g++) begin : g_slot
        assign slot_en[g] = accept && tag_ok && (obs.obs_tag_i == TagWidth'(g));
        aes_cmon_slot #(
            .DataWidth  (DataWidth),
            .CntWidth   (CntWidth),
            .AlertThresh(AlertThresh)
        ) u_slot (
            .clk_i       (clk_i),
            .rst_i       (rst_i),
            .clear_i     (clear_i),
            .obs_en_i    (slot_en[g]),
            .obs_data_i  (obs.obs_data_i),
            .match_o     (s_match[g]),
            .mismatch_o  (s_mismatch[g]),
            .alert_hit_o (s_alert_hit[g]),
            .period_hit_o(s_period_hit[g]),
            .iter_o      (s_iter[g]),
            .period_o    (s_period[g]),
            .diff_o      (s_diff[g])
        );
    end

    // Select the results of the one slot addressed this cycle.
    always_comb begin
        sel_match      = 1'b0;
        sel_mismatch   = 1'b0;
        sel_alert_hit  = 1'b0;
        sel_period_hit = 1'b0;
        sel_period     = '0;
        sel_cap        = '0;
        for (int i = 0; i < NumSlots; i++) begin
            if (slot_en[i]) begin
                sel_match      = s_match[i];
                sel_mismatch   = s_mismatch[i];
                sel_alert_hit  = s_alert_hit[i];
                sel_period_hit = s_period_hit[i];
                sel_period     = s_period[i];
                sel_cap.slot   = TagWidth'(i);
                sel_cap.iter   = s_iter[i];
                sel_cap.diff   = s_diff[i];
            end
        end
    end

    // Next values of the result pulses; period_o holds the last confirmed interval.
    always_comb begin
        match_d        = sel_match;
        mismatch_d     = sel_mismatch;
        tag_err_d      = accept && !tag_ok;
        period_valid_d = sel_period_hit;
        period_d       = sel_period_hit ? sel_period : period_q;
    end

    // Result pulse registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            match_q        <= 1'b0;
            mismatch_q     <= 1'b0;
            tag_err_q      <= 1'b0;
            period_valid_q <= 1'b0;
            period_q       <= '0;
        end else begin
            match_q        <= match_d;
            mismatch_q     <= mismatch_d;
            tag_err_q      <= tag_err_d;
            period_valid_q <= period_valid_d;
            period_q       <= period_d;
        end
    end

    // Alert FSM: a clear and a new trigger in the same cycle leaves a fresh capture.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            alert_state_q <= ALERT_IDLE;
            cap_valid_q   <= 1'b0;
            cap_q         <= '0;
        end else if (sel_alert_hit && (alert_state_q == ALERT_IDLE || alert_clr_i)) begin
            alert_state_q <= ALERT_ACTIVE;
            cap_valid_q   <= 1'b1;
            cap_q         <= sel_cap;
        end else if (alert_clr_i) begin
            alert_state_q <= ALERT_IDLE;
            cap_valid_q   <= 1'b0;
            cap_q         <= '0;
        end
    end

    assign match_o        = match_q;
    assign mismatch_o     = mismatch_q;
    assign tag_err_o      = tag_err_q;
    assign period_valid_o = period_valid_q;
    assign period_o       = period_q;
    assign alert_o        = (alert_state_q == ALERT_ACTIVE);
    assign cap_valid_o    = cap_valid_q;
    assign cap_slot_o     = cap_q.slot;
    assign cap_iter_o     = cap_q.iter;
    assign cap_diff_o     = cap_q.diff;
endmodule

// File: tb/tb_aes_ct_consistency_monitor.sv
// Directed bench for the ciphertext consistency monitor (five slots so an
// out-of-range tag is representable). Expected outputs come from a small
// behavioural model, queued per cycle and popped when the outputs settle.
module tb_aes_ct_consistency_monitor;
    localparam int NS = 5;

    typedef struct {
        logic         match, mismatch, tag_err, period_valid, alert, cap_valid;
        logic [15:0]  period, cap_iter;
        logic [2:0]   cap_slot;
        logic [127:0] cap_diff;
    } exp_t;

    logic clk = 1'b0, rst = 1'b1, clear = 1'b0, alert_clr = 1'b0;
    logic match_o, mismatch_o, tag_err_o, alert_o, cap_valid_o, period_valid_o;
    logic [2:0]   cap_slot_o;
    logic [15:0]  cap_iter_o, period_o;
    logic [127:0] cap_diff_o;

    int checks = 0, failures = 0, match_seen = 0, period_seen = 0;
    exp_t sb_q[$];

    logic [127:0] m_ref [NS];
    logic [15:0]  m_iter [NS], m_mm [NS], m_last [NS], m_prev [NS];
    bit           m_armed [NS], m_hl [NS], m_hp [NS];
    bit           m_alert;
    logic [2:0]   m_cslot;
    logic [15:0]  m_citer, m_period;
    logic [127:0] m_cdiff;
    logic [127:0] kv, blk [4];

    always #5 clk = ~clk;

    aes_ct_consistency_monitor_if #(.DataWidth(128), .TagWidth(3)) ifc ();

    aes_ct_consistency_monitor #(
        .DataWidth(128), .NumSlots(NS), .CntWidth(16), .AlertThresh(1)
    ) dut (
        .clk_i(clk), .rst_i(rst), .clear_i(clear), .alert_clr_i(alert_clr),
        .obs(ifc),
        .match_o(match_o), .mismatch_o(mismatch_o), .tag_err_o(tag_err_o),
        .alert_o(alert_o), .cap_valid_o(cap_valid_o), .cap_slot_o(cap_slot_o),
        .cap_iter_o(cap_iter_o), .cap_diff_o(cap_diff_o),
        .period_valid_o(period_valid_o), .period_o(period_o)
    );

    task automatic chk(input string name, input logic [127:0] obs_v, input logic [127:0] exp_v);
        checks++;
        assert (obs_v === exp_v) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs_v, exp_v);
        end
    endtask

    task automatic clear_slots();
        for (int i = 0; i < NS; i++) begin
            m_armed[i] = 0; m_ref[i] = '0; m_iter[i] = '0; m_mm[i] = '0;
            m_last[i] = '0; m_prev[i] = '0; m_hl[i] = 0; m_hp[i] = 0;
        end
    endtask

    // One clock: drive inputs, model the expected outcome, then compare.
    task automatic step(input bit r, input bit clr, input bit aclr, input bit v,
                        input logic [2:0] tag, input logic [127:0] d);
        exp_t e, x;
        bit hit;
        logic [15:0] nit, intv;
        logic [2:0] hslot;
        logic [127:0] hdiff;
        rst = r; clear = clr; alert_clr = aclr;
        ifc.obs_valid_i = v; ifc.obs_tag_i = tag; ifc.obs_data_i = d;
        e.match = 0; e.mismatch = 0; e.tag_err = 0; e.period_valid = 0;
        hit = 0; hslot = '0; nit = '0; hdiff = '0;
        if (r) begin
            clear_slots();
            m_alert = 0; m_cslot = '0; m_citer = '0; m_cdiff = '0; m_period = '0;
        end else begin
            if (clr) clear_slots();
            else if (v) begin
                if (int'(tag) >= NS) e.tag_err = 1;
                else if (!m_armed[tag]) begin
                    m_armed[tag] = 1; m_ref[tag] = d; m_iter[tag] = '0;
                end else begin
                    nit = (m_iter[tag] == 16'hffff) ? m_iter[tag] : m_iter[tag] + 16'd1;
                    m_iter[tag] = nit;
                    if (d == m_ref[tag]) e.match = 1;
                    else begin
                        e.mismatch = 1;
                        hit = (m_mm[tag] == 16'd0);
                        if (m_mm[tag] != 16'hffff) m_mm[tag] = m_mm[tag] + 16'd1;
                        intv = nit - m_last[tag];
                        if (m_hp[tag] && intv == m_prev[tag] && intv != 0) begin
                            e.period_valid = 1; m_period = intv;
                        end
                        if (m_hl[tag]) begin m_prev[tag] = intv; m_hp[tag] = 1; end
                        m_last[tag] = nit; m_hl[tag] = 1;
                        hslot = tag; hdiff = d ^ m_ref[tag];
                    end
                end
            end
            if (hit && (!m_alert || aclr)) begin
                m_alert = 1; m_cslot = hslot; m_citer = nit; m_cdiff = hdiff;
            end else if (aclr) begin
                m_alert = 0; m_cslot = '0; m_citer = '0; m_cdiff = '0;
            end
        end
        e.period = m_period; e.alert = m_alert; e.cap_valid = m_alert;
        e.cap_slot = m_cslot; e.cap_iter = m_citer; e.cap_diff = m_cdiff;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        if (match_o === 1'b1) match_seen++;
        if (period_valid_o === 1'b1) period_seen++;
        x = sb_q.pop_front();
        chk("match", match_o, x.match);
        chk("mismatch", mismatch_o, x.mismatch);
        chk("tag_err", tag_err_o, x.tag_err);
        chk("period_valid", period_valid_o, x.period_valid);
        chk("period", period_o, x.period);
        chk("alert", alert_o, x.alert);
        chk("cap_valid", cap_valid_o, x.cap_valid);
        chk("cap_slot", cap_slot_o, x.cap_slot);
        chk("cap_iter", cap_iter_o, x.cap_iter);
        chk("cap_diff", cap_diff_o, x.cap_diff);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        kv = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
        for (int i = 0; i < 4; i++) blk[i] = kv ^ (128'(i + 1) << 64);

        // Reset
        step(1, 0, 0, 0, 3'd0, '0);
        step(1, 0, 0, 0, 3'd0, '0);
        chk("reset_alert", alert_o, 1'b0);
        chk("reset_period", period_o, 16'd0);

        // 300 identical observations on slot 0
        match_seen = 0;
        for (int i = 0; i < 300; i++) step(0, 0, 0, 1, 3'd0, kv);
        chk("match_count_300", match_seen, 299);
        chk("no_alert_300", alert_o, 1'b0);

        // Bit 0 flipped at iteration 5
        step(0, 1, 0, 0, 3'd0, '0);
        for (int it = 0; it <= 5; it++) step(0, 0, 0, 1, 3'd0, (it == 5) ? kv ^ 128'h1 : kv);
        chk("it5_mismatch", mismatch_o, 1'b1);
        chk("it5_alert", alert_o, 1'b1);
        chk("it5_cap_slot", cap_slot_o, 3'd0);
        chk("it5_cap_iter", cap_iter_o, 16'd5);
        chk("it5_cap_diff", cap_diff_o, 128'h1);

        // Alert clear
        step(0, 0, 1, 0, 3'd0, '0);
        chk("clr_alert", alert_o, 1'b0);
        chk("clr_cap_valid", cap_valid_o, 1'b0);

        // Periodic flips at 10, 20, 30
        step(0, 1, 0, 0, 3'd0, '0);
        period_seen = 0;
        for (int it = 0; it <= 35; it++) begin
            step(0, 0, 0, 1, 3'd0, (it == 10 || it == 20 || it == 30) ? kv ^ 128'h8 : kv);
            if (it == 30) begin
                chk("per30_valid", period_valid_o, 1'b1);
                chk("per30_value", period_o, 16'd10);
            end
        end
        chk("period_pulses", period_seen, 1);
        chk("per_cap_iter", cap_iter_o, 16'd10);
        step(0, 0, 1, 0, 3'd0, '0);
        step(0, 1, 0, 0, 3'd0, '0);

        // Four slots interleaved, one mismatch on slot 2 in round 2
        for (int r = 0; r < 4; r++)
            for (int s = 0; s < 4; s++)
                step(0, 0, 0, 1, 3'(s), (r == 2 && s == 2) ? blk[2] ^ 128'hff00 : blk[s]);
        chk("ms_cap_slot", cap_slot_o, 3'd2);
        chk("ms_cap_iter", cap_iter_o, 16'd2);
        chk("ms_cap_diff", cap_diff_o, 128'hff00);
        step(0, 0, 1, 0, 3'd0, '0);

        // Clear with a same-cycle observation, then re-arm
        step(0, 1, 0, 1, 3'd0, kv);
        chk("clr_obs_no_pulse", match_o | mismatch_o, 1'b0);
        step(0, 0, 0, 1, 3'd0, kv);
        chk("rearm_no_pulse", match_o | mismatch_o, 1'b0);
        step(0, 0, 0, 1, 3'd0, kv);
        chk("rearm_match", match_o, 1'b1);

        // Out-of-range tags
        step(0, 0, 0, 1, 3'd5, kv);
        chk("tag5_err", tag_err_o, 1'b1);
        step(0, 0, 0, 1, 3'd7, ~kv);
        step(0, 0, 0, 1, 3'd0, kv);

        // Alert clear colliding with a new trigger; later mismatch must not overwrite
        step(0, 0, 0, 1, 3'd1, blk[1]);
        step(0, 0, 0, 1, 3'd1, blk[1] ^ 128'h2);
        step(0, 0, 0, 1, 3'd3, blk[3]);
        step(0, 0, 1, 1, 3'd3, blk[3] ^ 128'h4);
        chk("coll_alert", alert_o, 1'b1);
        chk("coll_cap_slot", cap_slot_o, 3'd3);
        chk("coll_cap_diff", cap_diff_o, 128'h4);
        step(0, 0, 0, 1, 3'd0, kv ^ 128'h10);
        chk("hold_cap_slot", cap_slot_o, 3'd3);

        // Reset mid-stream
        step(1, 0, 0, 1, 3'd0, kv);
        chk("midrst_alert", alert_o, 1'b0);
        step(0, 0, 0, 1, 3'd0, kv);
        step(0, 0, 0, 1, 3'd0, kv);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
